memory_single: RTL and testbench

MEMORY_SINGLE -- requirements
Module: memory_single

---
 rtl/memory_single.sv | 67 ++++++
 tb/tb_memory_single.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/memory_single.sv
// Single-port synchronous RAM with read-first ordering and 1-cycle registered read.
// Define MEMORY_SINGLE_PARITY_EN to store a per-word parity bit and flag mismatches on read.
module memory_single #(
    parameter int data_0_WIDTH = 16,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [data_0_WIDTH-1:0] data_in,
    input  logic                    we,
    output logic [data_0_WIDTH-1:0] data_out,
    input  logic                    parity_inj,
    output logic                    parity_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Contents start at zero and are deliberately untouched by reset.
    logic [data_0_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic write_en;
    assign write_en = we && !reset;

    // Read stage: the array is sampled before this edge's write lands (read-first).
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
        end else begin
            data_out <= mem[address];
        end
    end

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[address] <= data_in;
        end
    end

`ifdef MEMORY_SINGLE_PARITY_EN
    function automatic logic word_parity(input logic [data_0_WIDTH-1:0] word);
        return ^word;
    endfunction

    // Never-written words hold data 0 with parity 0, so they read back clean.
    logic par_mem [DEPTH] = '{default: 1'b0};

    always_ff @(posedge clk) begin
        if (write_en) begin
            par_mem[address] <= word_parity(data_in) ^ parity_inj;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= word_parity(mem[address]) ^ par_mem[address];
        end
    end
`else
    logic unused_parity_inj;
    assign unused_parity_inj = parity_inj;
    assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_memory_single.sv
// Self-checking bench for memory_single: behavioural model plus directed literal checks and random traffic.
module tb_memory_single;

`ifdef MEMORY_SINGLE_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [7:0]  address;
    logic [15:0] data_in;
    logic        we;
    logic [15:0] data_out;
    logic        parity_inj;
    logic        parity_err;

    memory_single #(.data_0_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in), .we(we),
        .data_out(data_out), .parity_inj(parity_inj), .parity_err(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a word array plus a "written with injected error" flag per word.
    logic [15:0] m [256] = '{default: 16'h0000};
    logic        bad [256] = '{default: 1'b0};
    logic [15:0] exp_d = 16'h0;
    logic        exp_p = 1'b0;
    bit          started = 1'b0;

    // Literal expectation for the edge about to happen, delayed to line up with the output.
    bit          lit_chk = 1'b0, cur_chk = 1'b0;
    logic [15:0] lit_d = 16'h0, cur_d = 16'h0;
    logic        lit_p = 1'b0, cur_p = 1'b0;
    string       lit_name = "", cur_name = "";

    int n_tests = 0;
    int n_fail  = 0;

    always @(posedge clk) begin
        cur_chk  <= lit_chk;
        cur_d    <= lit_d;
        cur_p    <= lit_p;
        cur_name <= lit_name;
        if (reset) begin
            exp_d   <= 16'h0;
            exp_p   <= 1'b0;
            started <= 1'b1;
        end else begin
            exp_d <= m[address];
            exp_p <= PAR && bad[address];
            if (we) begin
                m[address]   <= data_in;
                bad[address] <= parity_inj;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            n_tests++;
            if (data_out !== exp_d || parity_err !== exp_p) begin
                n_fail++;
                $display("FAIL model t=%0t: data_out=%h parity_err=%b, expected %h/%b",
                         $time, data_out, parity_err, exp_d, exp_p);
            end
            if (cur_chk) begin
                n_tests++;
                if (data_out !== cur_d || parity_err !== cur_p) begin
                    n_fail++;
                    $display("FAIL %s: data_out=%h parity_err=%b, expected %h/%b",
                             cur_name, data_out, parity_err, cur_d, cur_p);
                end
            end
        end
    end

    task automatic tick(input logic r, input logic w, input logic [7:0] a, input logic [15:0] d,
                        input logic inj, input bit chk, input logic [15:0] ed, input logic ep,
                        input string nm);
        reset      = r;
        we         = w;
        address    = a;
        data_in    = d;
        parity_inj = inj;
        lit_chk    = chk;
        lit_d      = ed;
        lit_p      = ep;
        lit_name   = nm;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; address = 8'h0; data_in = 16'h0; parity_inj = 1'b0;

        tick(1, 0, 8'd0, 16'h0, 0, 1, 16'h0000, 0, "reset_state");
        tick(0, 0, 8'd255, 16'h0, 0, 1, 16'h0000, 0, "unwritten_255");

        for (int a = 0; a < 125; a++)
            tick(0, 1, 8'(a), 16'(2 * a), 0, 0, 16'h0, 0, "");
        for (int a = 0; a < 125; a++)
            tick(0, 0, 8'(a), 16'h0, 0, 1, 16'(2 * a), 0, "fill_readback");

        tick(0, 1, 8'd5, 16'h1111, 0, 0, 16'h0, 0, "");
        tick(0, 1, 8'd5, 16'h2222, 0, 1, 16'h1111, 0, "collision_old");
        tick(0, 0, 8'd5, 16'h0, 0, 1, 16'h2222, 0, "collision_new");

        tick(1, 1, 8'd3, 16'hFFFF, 0, 1, 16'h0000, 0, "reset_mid_1");
        tick(1, 1, 8'd3, 16'hFFFF, 0, 1, 16'h0000, 0, "reset_mid_2");
        tick(0, 0, 8'd3, 16'h0, 0, 1, 16'h0006, 0, "reset_retain_3");
        tick(0, 0, 8'd4, 16'h0, 0, 1, 16'h0008, 0, "reset_retain_4");

        tick(0, 1, 8'd7, 16'h0001, 1, 0, 16'h0, 0, "");
        tick(0, 0, 8'd7, 16'h0, 0, 1, 16'h0001, PAR, "parity_inj_on");
        tick(0, 1, 8'd7, 16'h0001, 0, 0, 16'h0, 0, "");
        tick(0, 0, 8'd7, 16'h0, 0, 1, 16'h0001, 0, "parity_inj_off");
        tick(0, 0, 8'd200, 16'h0, 0, 1, 16'h0000, 0, "unwritten_200");

        for (int i = 0; i < 3000; i++) begin
            logic        r, w, inj;
            logic [7:0]  a;
            logic [15:0] d;
            r   = ($urandom_range(0, 39) == 0);
            w   = 1'($urandom_range(0, 1));
            inj = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            d   = 16'($urandom);
            tick(r, w, a, d, inj, 0, 16'h0, 0, "");
        end

        tick(0, 0, 8'd0, 16'h0, 0, 0, 16'h0, 0, "");
        tick(0, 0, 8'd0, 16'h0, 0, 0, 16'h0, 0, "");
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
